// File: rtl/mstage_skid_bus_pkg.sv
// Shared definitions for the X->M pipeline register: build switch, reset PC,
// payload field widths, skid buffer state encodings and the packed X/M beat.
// Exports: CONFIG_MSTAGE_BUF, RST_PC_DEF, field widths, skid_state_e, xm_pay_t, helpers.
package mstage_skid_bus_pkg;

  // 1 = registered skid stage between X and M, 0 = plain wires
  localparam bit          CONFIG_MSTAGE_BUF = 1'b1;
  localparam logic [31:0] RST_PC_DEF        = 32'h8000_0000;

  localparam int XLEN     = 32;
  localparam int MASK_W   = 8;
  localparam int MRTYPE_W = 3;
  localparam int RDSRC_W  = 3;
  localparam int REG_W    = 5;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // One X->M beat: ALU result, store data, PC, CSR value and mem/wb controls
  typedef struct packed {
    logic [XLEN-1:0]     alures;
    logic [XLEN-1:0]     src2;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     csr;
    logic                mvalid;
    logic                mwen;
    logic [MASK_W-1:0]   mwmask;
    logic [MRTYPE_W-1:0] mrtype;
    logic [RDSRC_W-1:0]  rdregsrc;
    logic [REG_W-1:0]    rd;
  } xm_pay_t;

  localparam int PAY_W = $bits(xm_pay_t);

  // Value the M-side register takes in reset: everything zero except the PC
  function automatic xm_pay_t rst_payload(input logic [XLEN-1:0] pc);
    xm_pay_t p;
    p    = '0;
    p.pc = pc;
    return p;
  endfunction

  // Bits that must drop on a flush so a killed load/store cannot reach the LSU
  function automatic xm_pay_t flush_clr_mask();
    xm_pay_t p;
    p        = '0;
    p.mvalid = 1'b1;
    p.mwen   = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/mstage_skid_bus_if.sv
// Valid/ready beat bundle carrying one packed X->M payload per transfer.
// master: drives valid and dat, samples ready. slave: drives ready.
// Used on both the X-facing (slave) and M-facing (master) sides of the stage.
interface mstage_skid_bus_if;
  import mstage_skid_bus_pkg::*;

  logic    valid;
  logic    ready;
  xm_pay_t dat;

  modport master (
    output valid,
    output dat,
    input  ready
  );

  modport slave (
    input  valid,
    input  dat,
    output ready
  );

endinterface

// File: rtl/mstage_skid_bus_skid.sv
// Generic W-bit two-entry skid buffer: main reg drives the output, skid reg
// absorbs one extra beat so o_s_ready comes straight from a flop.
// Ports: i_clk/i_rst (sync, active-low), i_flush, s-side valid/ready/dat,
// m-side valid/ready/dat. Latency 1 cycle, 1 beat/cycle sustained.
module mstage_skid_bus_skid
  import mstage_skid_bus_pkg::*;
#(
  parameter int           W         = 8,
  parameter logic [W-1:0] RST_VAL   = '0,
  // bits of the main register forced low when a flush kills the contents
  parameter logic [W-1:0] FLUSH_CLR = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  input  logic [W-1:0] i_s_dat,
  output logic         o_m_valid,
  input  logic         i_m_ready,
  output logic [W-1:0] o_m_dat
);

  skid_state_e  r_state;
  skid_state_e  w_nxt;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_s_ready;
  logic         r_m_valid;

  logic w_s_fire;
  logic w_m_fire;
  logic w_ld_main;
  logic w_main_from_skid;
  logic w_ld_skid;

  assign w_s_fire = i_s_valid & r_s_ready;
  assign w_m_fire = r_m_valid & i_m_ready;

  always_comb begin
    w_nxt            = r_state;
    w_ld_main        = 1'b0;
    w_main_from_skid = 1'b0;
    w_ld_skid        = 1'b0;
    case (r_state)
      SKID_EMPTY: begin
        if (w_s_fire) begin
          w_nxt     = SKID_ONE;
          w_ld_main = 1'b1;
        end
      end
      SKID_ONE: begin
        if (w_s_fire && !w_m_fire) begin
          w_nxt     = SKID_FULL;
          w_ld_skid = 1'b1;
        end else if (!w_s_fire && w_m_fire) begin
          w_nxt = SKID_EMPTY;
        end else if (w_s_fire && w_m_fire) begin
          // head leaves while a new beat arrives: refill main directly
          w_ld_main = 1'b1;
        end
      end
      SKID_FULL: begin
        if (w_m_fire) begin
          w_nxt            = SKID_ONE;
          w_ld_main        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_nxt = SKID_EMPTY;
    endcase
    // flush wins over any transfer in the same cycle; offered beat is dropped
    if (i_flush) begin
      w_nxt            = SKID_EMPTY;
      w_ld_main        = 1'b0;
      w_main_from_skid = 1'b0;
      w_ld_skid        = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= SKID_EMPTY;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Handshake flops are loaded from the next-state decode so they always equal
  // (state!=FULL)/(state!=EMPTY); ready is additionally held low while in reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_s_ready <= (w_nxt != SKID_FULL);
      r_m_valid <= (w_nxt != SKID_EMPTY);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_main <= RST_VAL;
      r_skid <= '0;
    end else begin
      if (i_flush) begin
        r_main <= r_main & ~FLUSH_CLR;
      end else if (w_ld_main) begin
        r_main <= w_main_from_skid ? r_skid : i_s_dat;
      end
      if (w_ld_skid) begin
        r_skid <= i_s_dat;
      end
    end
  end

  assign o_s_ready = r_s_ready;
  assign o_m_valid = r_m_valid;
  assign o_m_dat   = r_main;

endmodule

// File: rtl/mstage_skid_bus.sv
// X->M pipeline register: receives the X-stage beat bundle and presents it to
// the LSU/M stage through a 2-entry skid buffer (s_ready purely registered).
// Ports: i_clk, i_rst (sync active-low), i_flush, x_if (slave, from X),
// m_if (master, to M). BYPASS=1 turns the stage into wires and ignores flush.
module mstage_skid_bus
  import mstage_skid_bus_pkg::*;
#(
  parameter logic [31:0] RST_PC = RST_PC_DEF,
  parameter bit          BYPASS = !CONFIG_MSTAGE_BUF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  mstage_skid_bus_if.slave  x_if,
  mstage_skid_bus_if.master m_if
);

  localparam logic [PAY_W-1:0] L_RST_VAL   = rst_payload(RST_PC);
  localparam logic [PAY_W-1:0] L_FLUSH_CLR = flush_clr_mask();

  generate
    if (BYPASS) begin : g_bypass
      // upstream owns kill in this configuration, so flush has no effect here
      assign x_if.ready = m_if.ready;
      assign m_if.valid = x_if.valid;
      assign m_if.dat   = x_if.dat;
    end else begin : g_buf
      logic [PAY_W-1:0] w_s_dat;
      logic [PAY_W-1:0] w_m_dat;
      logic             w_s_ready;
      logic             w_m_valid;

      assign w_s_dat = x_if.dat;

      mstage_skid_bus_skid #(
        .W         (PAY_W),
        .RST_VAL   (L_RST_VAL),
        .FLUSH_CLR (L_FLUSH_CLR)
      ) u_skid (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_flush   (i_flush),
        .i_s_valid (x_if.valid),
        .o_s_ready (w_s_ready),
        .i_s_dat   (w_s_dat),
        .o_m_valid (w_m_valid),
        .i_m_ready (m_if.ready),
        .o_m_dat   (w_m_dat)
      );

      assign x_if.ready = w_s_ready;
      assign m_if.valid = w_m_valid;
      assign m_if.dat   = w_m_dat;
    end
  endgenerate

endmodule

// File: tb/tb_mstage_skid_bus.sv
// Bench for mstage_skid_bus: directed scenarios with literal expectations plus
// a queue-based reference model compared every cycle on the falling edge.
// Inputs change 2 time units after each rising edge.
module tb_mstage_skid_bus;
  import mstage_skid_bus_pkg::*;

  logic clk;
  logic rst;
  logic flush;

  mstage_skid_bus_if x_if ();
  mstage_skid_bus_if m_if ();

  mstage_skid_bus #(
    .RST_PC (32'h8000_0000),
    .BYPASS (1'b0)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .x_if    (x_if),
    .m_if    (m_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_pay(input string nm, input xm_pay_t act, input xm_pay_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic xm_pay_t mk(input logic [31:0] a, input logic mv, input logic mw);
    xm_pay_t p;
    p          = '0;
    p.alures   = a;
    p.src2     = ~a;
    p.pc       = a << 2;
    p.csr      = a ^ 32'h5a5a_0000;
    p.mvalid   = mv;
    p.mwen     = mw;
    p.mwmask   = a[7:0];
    p.mrtype   = a[2:0];
    p.rdregsrc = a[5:3];
    p.rd       = a[4:0];
    return p;
  endfunction

  // Reference model: the stage is a FIFO of at most two beats
  xm_pay_t mq[$];
  xm_pay_t m_head;
  logic    m_rdy    = 1'b0;
  logic    m_vld    = 1'b0;
  logic    model_ok = 1'b0;

  initial begin
    logic sf, mf;
    forever begin
      @(posedge clk);
      if (!rst) begin
        mq.delete();
        m_rdy  = 1'b0;
        m_vld  = 1'b0;
        m_head = rst_payload(32'h8000_0000);
      end else begin
        sf = x_if.valid & m_rdy;
        mf = m_vld & m_if.ready;
        if (flush) begin
          mq.delete();
          m_head.mvalid = 1'b0;
          m_head.mwen   = 1'b0;
        end else begin
          if (mf) void'(mq.pop_front());
          if (sf) mq.push_back(x_if.dat);
          if (mq.size() > 0) m_head = mq[0];
        end
        m_rdy = (mq.size() < 2);
        m_vld = (mq.size() > 0);
      end
      model_ok = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("mdl_s_ready", {31'd0, x_if.ready}, {31'd0, m_rdy});
        chk("mdl_m_valid", {31'd0, m_if.valid}, {31'd0, m_vld});
        if (m_vld) chk_pay("mdl_payload", m_if.dat, m_head);
      end
    end
  end

  initial begin
    logic r;
    xm_pay_t p;
    rst        = 1'b0;
    flush      = 1'b0;
    x_if.valid = 1'b1;
    x_if.dat   = mk(32'hdead, 1'b1, 1'b1);
    m_if.ready = 1'b0;

    // Reset held 3 cycles with a beat offered
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_m_valid", {31'd0, m_if.valid}, 32'd0);
    chk("rst_pcM", m_if.dat.pc, 32'h8000_0000);
    chk("rst_rdM", {27'd0, m_if.dat.rd}, 32'd0);
    chk("rst_aluresM", m_if.dat.alures, 32'd0);
    chk("rst_s_ready", {31'd0, x_if.ready}, 32'd0);
    cyc();
    rst        = 1'b1;
    x_if.valid = 1'b0;
    @(negedge clk);
    chk("rel_s_ready_pre", {31'd0, x_if.ready}, 32'd0);
    cyc();
    @(negedge clk);
    chk("rel_s_ready", {31'd0, x_if.ready}, 32'd1);
    chk("rel_m_valid", {31'd0, m_if.valid}, 32'd0);

    // Streaming 8 beats, no bubbles
    m_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      x_if.valid = 1'b1;
      x_if.dat   = mk(i, 1'b0, 1'b0);
      @(negedge clk);
      if (i > 1) begin
        chk("stream_vld", {31'd0, m_if.valid}, 32'd1);
        chk("stream_dat", m_if.dat.alures, i - 1);
      end
    end
    cyc();
    x_if.valid = 1'b0;
    @(negedge clk);
    chk("stream_last", m_if.dat.alures, 32'd8);
    cyc();
    @(negedge clk);
    chk("stream_drain", {31'd0, m_if.valid}, 32'd0);

    // Backpressure: fill both entries, then drain in order
    cyc();
    m_if.ready = 1'b0;
    x_if.valid = 1'b1;
    x_if.dat   = mk(32'h10, 1'b0, 1'b0);
    cyc();
    x_if.dat   = mk(32'h20, 1'b0, 1'b0);
    cyc();
    x_if.valid = 1'b0;
    @(negedge clk);
    chk("bp_full_rdy", {31'd0, x_if.ready}, 32'd0);
    chk("bp_full_vld", {31'd0, m_if.valid}, 32'd1);
    chk("bp_head", m_if.dat.alures, 32'h10);
    cyc();
    @(negedge clk);
    chk("bp_hold", m_if.dat.alures, 32'h10);
    cyc();
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("bp_first", m_if.dat.alures, 32'h10);
    cyc();
    @(negedge clk);
    chk("bp_second", m_if.dat.alures, 32'h20);
    chk("bp_rdy_back", {31'd0, x_if.ready}, 32'd1);
    cyc();
    @(negedge clk);
    chk("bp_empty", {31'd0, m_if.valid}, 32'd0);

    // Simultaneous accept and deliver while holding one beat
    cyc();
    m_if.ready = 1'b0;
    x_if.valid = 1'b1;
    x_if.dat   = mk(32'h40, 1'b0, 1'b0);
    cyc();
    m_if.ready = 1'b1;
    x_if.dat   = mk(32'h41, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("sim_rdy", {31'd0, x_if.ready}, 32'd1);
      chk("sim_dat", m_if.dat.alures, 32'h40 + k - 1);
      cyc();
      x_if.dat = mk(32'h41 + k, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("sim_dat5", m_if.dat.alures, 32'h45);
    cyc();
    x_if.valid = 1'b0;
    @(negedge clk);
    chk("sim_dat6", m_if.dat.alures, 32'h46);
    cyc();
    @(negedge clk);
    chk("sim_empty", {31'd0, m_if.valid}, 32'd0);

    // Flush while full of stores, with a new beat offered
    cyc();
    m_if.ready = 1'b0;
    x_if.valid = 1'b1;
    x_if.dat   = mk(32'h31, 1'b1, 1'b1);
    cyc();
    x_if.dat   = mk(32'h32, 1'b1, 1'b1);
    cyc();
    x_if.dat   = mk(32'h99, 1'b1, 1'b1);
    flush      = 1'b1;
    @(negedge clk);
    chk("fl_full_rdy", {31'd0, x_if.ready}, 32'd0);
    chk("fl_full_mwen", {31'd0, m_if.dat.mwen}, 32'd1);
    cyc();
    flush      = 1'b0;
    x_if.valid = 1'b0;
    @(negedge clk);
    chk("fl_m_valid", {31'd0, m_if.valid}, 32'd0);
    chk("fl_mwenM", {31'd0, m_if.dat.mwen}, 32'd0);
    chk("fl_mvalidM", {31'd0, m_if.dat.mvalid}, 32'd0);
    chk("fl_s_ready", {31'd0, x_if.ready}, 32'd1);
    cyc();
    m_if.ready = 1'b1;
    x_if.valid = 1'b1;
    x_if.dat   = mk(32'h55, 1'b0, 1'b0);
    cyc();
    x_if.valid = 1'b0;
    @(negedge clk);
    chk("fl_next_vld", {31'd0, m_if.valid}, 32'd1);
    chk("fl_next_dat", m_if.dat.alures, 32'h55);
    cyc();
    @(negedge clk);
    chk("fl_next_gone", {31'd0, m_if.valid}, 32'd0);

    // Random traffic; also probe that s_ready ignores same-cycle m_ready
    for (int n = 0; n < 10000; n++) begin
      cyc();
      p.alures   = $urandom;
      p.src2     = $urandom;
      p.pc       = $urandom;
      p.csr      = $urandom;
      p.mvalid   = 1'($urandom_range(0, 1));
      p.mwen     = 1'($urandom_range(0, 1));
      p.mwmask   = 8'($urandom_range(0, 255));
      p.mrtype   = 3'($urandom_range(0, 7));
      p.rdregsrc = 3'($urandom_range(0, 7));
      p.rd       = 5'($urandom_range(0, 31));
      x_if.dat   = p;
      x_if.valid = ($urandom_range(0, 3) != 0);
      m_if.ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      #1;
      r = x_if.ready;
      m_if.ready = ~m_if.ready;
      #1;
      chk("rdy_comb_path", {31'd0, x_if.ready}, {31'd0, r});
      m_if.ready = ~m_if.ready;
    end
    cyc();
    flush      = 1'b0;
    x_if.valid = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
